// File: rtl/game_referee.sv
// Game referee: tracks the alive players, survival scores, eliminations and the winner.
// Optional high-score register is enabled with GAME_REFEREE_HISCORE_EN.
module game_referee #(
  parameter int MinLoc     = 0,
  parameter int MaxLoc     = 440,
  parameter int ScoreWidth = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [3:0]              player_en_i,
  input  logic                    score_tick_i,
  input  logic [8:0]              luc_loc0_i,
  input  logic [8:0]              luc_loc1_i,
  input  logic [8:0]              luc_loc2_i,
  input  logic [8:0]              luc_loc3_i,
  output logic [3:0]              alive_o,
  output logic [3:0]              elim_o,
  output logic [4*ScoreWidth-1:0] score_o,
  output logic [1:0]              state_o,
  output logic                    game_over_o,
  output logic [1:0]              winner_o,
  output logic                    winner_valid_o,
  output logic [ScoreWidth-1:0]   hiscore_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam logic [ScoreWidth-1:0] ScoreMax = '1;

  state_t                state;
  logic [3:0]            alive;
  logic [3:0]            elim;
  logic [ScoreWidth-1:0] score     [4];
  logic [ScoreWidth-1:0] score_nxt [4];
  logic [8:0]            loc       [4];
  logic [3:0]            oob;
  logic [3:0]            next_alive;
  logic                  multi;
  logic [1:0]            solo;
  logic                  game_over;
  logic [1:0]            winner;
  logic                  winner_valid;
  logic                  fresh;
  logic                  finish;

  function automatic logic [2:0] popcnt(input logic [3:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  // Lowest set bit; 0 for an empty mask.
  function automatic logic [1:0] first_idx(input logic [3:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  assign loc[0] = luc_loc0_i;
  assign loc[1] = luc_loc1_i;
  assign loc[2] = luc_loc2_i;
  assign loc[3] = luc_loc3_i;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      oob[n] = alive[n] &&
               (int'(loc[n]) < MinLoc || int'(loc[n]) > MaxLoc);
    end
    next_alive = alive & ~oob;
    for (int n = 0; n < 4; n++) begin
      score_nxt[n] = score[n];
      if (score_tick_i && next_alive[n] && score[n] != ScoreMax)
        score_nxt[n] = score[n] + ScoreWidth'(1);
    end
    fresh  = start_i && (|player_en_i) && (state != RUN);
    finish = multi ? (popcnt(next_alive) <= 3'd1) : (next_alive == 4'b0000);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      alive        <= '0;
      elim         <= '0;
      multi        <= 1'b0;
      solo         <= '0;
      game_over    <= 1'b0;
      winner       <= '0;
      winner_valid <= 1'b0;
      for (int n = 0; n < 4; n++) score[n] <= '0;
    end else begin
      elim <= '0;
      if (fresh) begin
        state        <= RUN;
        alive        <= player_en_i;
        multi        <= popcnt(player_en_i) >= 3'd2;
        solo         <= first_idx(player_en_i);
        game_over    <= 1'b0;
        winner_valid <= 1'b0;
        for (int n = 0; n < 4; n++) score[n] <= '0;
      end else begin
        unique case (state)
          IDLE: ;
          RUN: begin
            alive <= next_alive;
            elim  <= oob;
            for (int n = 0; n < 4; n++) score[n] <= score_nxt[n];
            if (finish) begin
              state     <= OVER;
              game_over <= 1'b1;
              if (multi) begin
                winner       <= first_idx(next_alive);
                winner_valid <= |next_alive;
              end else begin
                winner       <= solo;
                winner_valid <= 1'b0;
              end
            end
          end
          OVER: begin
            // Start with an empty mask abandons the game entirely.
            if (start_i) begin
              state        <= IDLE;
              alive        <= '0;
              game_over    <= 1'b0;
              winner       <= '0;
              winner_valid <= 1'b0;
              for (int n = 0; n < 4; n++) score[n] <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef GAME_REFEREE_HISCORE_EN
  logic [ScoreWidth-1:0] hiscore;
  logic [ScoreWidth-1:0] best;

  always_comb begin
    best = score[0];
    for (int n = 1; n < 4; n++) if (score[n] > best) best = score[n];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) hiscore <= '0;
    else if (best > hiscore) hiscore <= best;
  end

  assign hiscore_o = hiscore;
`else
  assign hiscore_o = '0;
`endif

  for (genvar n = 0; n < 4; n++) begin : g_score
    assign score_o[n*ScoreWidth +: ScoreWidth] = score[n];
  end

  assign alive_o        = alive;
  assign elim_o         = elim;
  assign state_o        = state;
  assign game_over_o    = game_over;
  assign winner_o       = winner;
  assign winner_valid_o = winner_valid;

endmodule

// File: tb/tb_game_referee.sv
// Scoreboard bench for game_referee: a rule-level model queues the expected
// outputs per cycle and a monitor compares them against the DUT.
module tb_game_referee;

  localparam int SW   = 4;
  localparam int MINL = 0;
  localparam int MAXL = 440;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [3:0]    player_en_i = '0;
  logic          score_tick_i = 1'b0;
  logic [8:0]    luc_loc0_i = 9'd200;
  logic [8:0]    luc_loc1_i = 9'd200;
  logic [8:0]    luc_loc2_i = 9'd200;
  logic [8:0]    luc_loc3_i = 9'd200;
  logic [3:0]    alive_o;
  logic [3:0]    elim_o;
  logic [4*SW-1:0] score_o;
  logic [1:0]    state_o;
  logic          game_over_o;
  logic [1:0]    winner_o;
  logic          winner_valid_o;
  logic [SW-1:0] hiscore_o;

  always #5 clk = ~clk;

  game_referee #(.MinLoc(MINL), .MaxLoc(MAXL), .ScoreWidth(SW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .player_en_i    (player_en_i),
    .score_tick_i   (score_tick_i),
    .luc_loc0_i     (luc_loc0_i),
    .luc_loc1_i     (luc_loc1_i),
    .luc_loc2_i     (luc_loc2_i),
    .luc_loc3_i     (luc_loc3_i),
    .alive_o        (alive_o),
    .elim_o         (elim_o),
    .score_o        (score_o),
    .state_o        (state_o),
    .game_over_o    (game_over_o),
    .winner_o       (winner_o),
    .winner_valid_o (winner_valid_o),
    .hiscore_o      (hiscore_o)
  );

  typedef struct {
    int st;
    int alive;
    int elim;
    int score;
    int go;
    int win;
    int wv;
    int hi;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Stimulus for the next edge.
  bit   r_rst, r_start, r_tick;
  int   r_en;
  int   r_loc[4];

  // Reference model: 0 idle, 1 running, 2 game over.
  int   m_st, m_alive, m_elim, m_go, m_win, m_wv, m_hi;
  int   m_score[4];
  int   m_players, m_solo;

  function automatic int lowest(input int mask);
    for (int i = 0; i < 4; i++) if (mask[i]) return i;
    return 0;
  endfunction

  task automatic new_round();
    m_st = 1;
    m_alive = r_en;
    m_players = $countones(r_en[3:0]);
    m_solo = lowest(r_en);
    m_go = 0;
    m_wv = 0;
    for (int n = 0; n < 4; n++) m_score[n] = 0;
  endtask

  task automatic model();
    int mx;
    int oob;
    if (r_rst) begin
      m_st = 0; m_alive = 0; m_elim = 0; m_go = 0;
      m_win = 0; m_wv = 0; m_hi = 0;
      for (int n = 0; n < 4; n++) m_score[n] = 0;
      return;
    end
    mx = 0;
    for (int n = 0; n < 4; n++) if (m_score[n] > mx) mx = m_score[n];
`ifdef GAME_REFEREE_HISCORE_EN
    if (mx > m_hi) m_hi = mx;
`endif
    m_elim = 0;
    case (m_st)
      0: if (r_start && r_en != 0) new_round();
      1: begin
        oob = 0;
        for (int n = 0; n < 4; n++)
          if (m_alive[n] && (r_loc[n] < MINL || r_loc[n] > MAXL)) oob |= (1 << n);
        m_elim = oob;
        m_alive = m_alive & ~oob;
        for (int n = 0; n < 4; n++)
          if (r_tick && m_alive[n] && m_score[n] < SMAX) m_score[n]++;
        if (m_players >= 2 && $countones(m_alive[3:0]) <= 1) begin
          m_st = 2; m_go = 1;
          m_win = lowest(m_alive);
          m_wv = (m_alive != 0);
        end else if (m_players == 1 && m_alive == 0) begin
          m_st = 2; m_go = 1; m_win = m_solo; m_wv = 0;
        end
      end
      default: if (r_start) begin
        if (r_en != 0) new_round();
        else begin
          m_st = 0; m_alive = 0; m_go = 0; m_win = 0; m_wv = 0;
          for (int n = 0; n < 4; n++) m_score[n] = 0;
        end
      end
    endcase
  endtask

  task automatic cyc();
    exp_t e;
    @(negedge clk);
    rst_i = r_rst;
    start_i = r_start;
    player_en_i = 4'(r_en);
    score_tick_i = r_tick;
    luc_loc0_i = 9'(r_loc[0]);
    luc_loc1_i = 9'(r_loc[1]);
    luc_loc2_i = 9'(r_loc[2]);
    luc_loc3_i = 9'(r_loc[3]);
    model();
    e.st = m_st; e.alive = m_alive; e.elim = m_elim; e.go = m_go;
    e.win = m_win; e.wv = m_wv; e.hi = m_hi;
    e.score = 0;
    for (int n = 0; n < 4; n++) e.score |= m_score[n] << (n * SW);
    q.push_back(e);
  endtask

  task automatic idle_in(input int cnt);
    r_rst = 0; r_start = 0; r_tick = 0;
    for (int i = 0; i < cnt; i++) cyc();
  endtask

  task automatic locs(input int a, input int b, input int c, input int d);
    r_loc[0] = a; r_loc[1] = b; r_loc[2] = c; r_loc[3] = d;
  endtask

  function automatic void check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("state", int'(state_o), e.st);
      check("alive", int'(alive_o), e.alive);
      check("elim", int'(elim_o), e.elim);
      check("score", int'(score_o), e.score);
      check("game_over", int'(game_over_o), e.go);
      check("winner", int'(winner_o), e.win);
      check("winner_valid", int'(winner_valid_o), e.wv);
      check("hiscore", int'(hiscore_o), e.hi);
    end
  end

  initial begin
    r_rst = 1; r_start = 0; r_tick = 0; r_en = 0;
    locs(200, 200, 200, 200);
    m_players = 0; m_solo = 0;
    for (int i = 0; i < 3; i++) cyc();
    idle_in(2);

    // Four-player round, five ticks.
    r_start = 1; r_en = 4'b1111; cyc();
    idle_in(1);
    r_tick = 1;
    for (int i = 0; i < 5; i++) cyc();
    idle_in(1);

    // Player 2 leaves at the bottom while a tick arrives.
    locs(200, 200, 441, 200); r_tick = 1; cyc();
    locs(200, 200, 200, 200); idle_in(3);

    // Players 0 and 3 leave on different cycles; player 1 wins.
    locs(500, 200, 200, 200); cyc();
    locs(200, 200, 200, 200); idle_in(2);
    locs(200, 200, 200, 441); cyc();
    locs(200, 200, 200, 200);
    r_tick = 1;
    for (int i = 0; i < 3; i++) cyc();

    // Restart from game over; both survivors leave together -> draw.
    r_tick = 0; r_start = 1; r_en = 4'b0011; cyc();
    r_start = 0; r_tick = 1; cyc(); cyc();
    locs(441, 511, 200, 200); cyc();
    locs(200, 200, 200, 200); idle_in(2);

    // Zero-enable start leaves game over, then is ignored in idle.
    r_start = 1; r_en = 0; cyc();
    r_start = 1; r_en = 0; cyc();
    idle_in(2);

    // Single-player round saturates, then the lone player exits.
    r_start = 1; r_en = 4'b0100; cyc();
    r_start = 0; r_tick = 1;
    locs(0, 0, 440, 0);
    for (int i = 0; i < 20; i++) cyc();
    locs(200, 200, 441, 200); cyc();
    locs(200, 200, 200, 200); idle_in(2);
    r_start = 1; r_en = 4'b1111; cyc();
    idle_in(2);

    // Reset mid-round with a pending elimination.
    r_tick = 1; cyc(); cyc();
    r_rst = 1; locs(441, 200, 200, 200); cyc();
    locs(200, 200, 200, 200); idle_in(2);

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      r_rst = ($urandom_range(0, 599) == 0);
      r_start = ($urandom_range(0, 11) == 0);
      r_en = $urandom_range(0, 15);
      r_tick = $urandom_range(0, 1);
      for (int n = 0; n < 4; n++) begin
        case ($urandom_range(0, 39))
          0: r_loc[n] = $urandom_range(441, 511);
          1: r_loc[n] = 441;
          2: r_loc[n] = 440;
          3: r_loc[n] = 0;
          default: r_loc[n] = $urandom_range(0, 440);
        endcase
      end
      cyc();
    end
    idle_in(1);

    @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
